// File: rtl/vim828_pkg.sv
// Shared constants and types for the VIM828 text front-end.
package vim828_pkg;

  // Segment bit positions within a 14-bit digit pattern (NMLK_JIHGF_EDCBA).
  typedef enum int unsigned {
    SegA = 0,
    SegB = 1,
    SegC = 2,
    SegD = 3,
    SegE = 4,
    SegF = 5,
    SegG = 6,
    SegH = 7,
    SegI = 8,
    SegJ = 9,
    SegK = 10,
    SegL = 11,
    SegM = 12,
    SegN = 13
  } seg_pos_e;

  localparam logic [13:0] BLANK = 14'h0000;

  typedef enum logic {
    StIdle,
    StLoad
  } load_state_e;

  typedef enum logic [1:0] {
    StWait,
    StFetch,
    StCommit
  } refresh_state_e;

  // Lowercase letters share the uppercase glyphs.
  function automatic logic [6:0] fold_case(input logic [6:0] c);
    if (c >= 7'h61 && c <= 7'h7a) begin
      return c - 7'h20;
    end
    return c;
  endfunction

endpackage

// File: rtl/vim828_font14.sv
// Combinational 7-bit ASCII to 14-segment glyph ROM.
module vim828_font14
  import vim828_pkg::*;
(
  input  logic [6:0]  code_i,
  output logic [13:0] seg_o
);

  // Glyphs for 0x20..0x5F, eight codes per row.
  localparam logic [13:0] Glyph [64] = '{
    14'h0000, 14'h0208, 14'h0202, 14'h12CE, 14'h12ED, 14'h2C24, 14'h0D59, 14'h0200,
    14'h0C00, 14'h2100, 14'h3FC0, 14'h12C0, 14'h2000, 14'h00C0, 14'h1000, 14'h2400,
    14'h243F, 14'h0006, 14'h00DB, 14'h008F, 14'h00E6, 14'h0869, 14'h00FD, 14'h0007,
    14'h00FF, 14'h00EF, 14'h1200, 14'h2200, 14'h0C40, 14'h00C8, 14'h2180, 14'h1083,
    14'h02BB, 14'h00F7, 14'h128F, 14'h0039, 14'h120F, 14'h00F9, 14'h0071, 14'h00BD,
    14'h00F6, 14'h1209, 14'h001E, 14'h0C70, 14'h0038, 14'h0536, 14'h0936, 14'h003F,
    14'h00F3, 14'h083F, 14'h08F3, 14'h00ED, 14'h1201, 14'h003E, 14'h2430, 14'h2836,
    14'h2D00, 14'h1500, 14'h2409, 14'h0039, 14'h0900, 14'h000F, 14'h2800, 14'h0008
  };

  logic [6:0] folded;
  logic [5:0] idx;

  // Fold case, then look up printable codes; everything else is blank.
  always_comb begin
    folded = fold_case(code_i);
    idx    = 6'(folded - 7'h20);
    seg_o  = BLANK;
    if (folded >= 7'h20 && folded <= 7'h5f) begin
      seg_o = Glyph[idx];
    end
  end

endmodule

// File: rtl/vim828_text_controller.sv
// Double-buffered text loader, scroller and frame builder for the VIM828 LCD driver.
module vim828_text_controller
  import vim828_pkg::*;
#(
  parameter int unsigned CLOCK_HZ  = 1_000_000,
  parameter int unsigned SCROLL_MS = 300,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned GAP       = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start_i,
  input  logic        End_i,
  input  logic [7:0]  Char_i,
  input  logic        Valid_i,
  output logic        Ready_o,
  output logic [13:0] Segments7_o,
  output logic [13:0] Segments6_o,
  output logic [13:0] Segments5_o,
  output logic [13:0] Segments4_o,
  output logic [13:0] Segments3_o,
  output logic [13:0] Segments2_o,
  output logic [13:0] Segments1_o,
  output logic [13:0] Segments0_o,
  output logic [7:0]  DecimalPoints_o,
  output logic        Updated_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  // Wide enough for offset + 7 before the single wrap subtraction.
  localparam int unsigned IW    = $clog2(DEPTH + GAP + 8) + 1;
  localparam int unsigned Ticks = CLOCK_HZ / 1000 * SCROLL_MS;
  localparam int unsigned TW    = (Ticks > 1) ? $clog2(Ticks) : 1;

  load_state_e    load_state_q, load_state_d;
  refresh_state_e ref_state_q, ref_state_d;

  logic [7:0]    mem_q [2][DEPTH];
  logic [7:0]    mem_d [2][DEPTH];
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];
  logic          active_q, active_d;
  logic [IW-1:0] offset_q, offset_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          pending_q, pending_d;
  logic [2:0]    digit_q, digit_d;
  logic [13:0]   stage_seg_q [8];
  logic [13:0]   stage_seg_d [8];
  logic [7:0]    stage_dp_q, stage_dp_d;
  logic [13:0]   out_seg_q [8];
  logic [13:0]   out_seg_d [8];
  logic [7:0]    out_dp_q, out_dp_d;

  logic          shadow;
  logic          accept;
  logic          commit;
  logic          tick;
  logic          scroll_en;
  logic          scroll_req;
  logic          refresh_req;
  logic [LW-1:0] act_len;
  logic [IW-1:0] span;
  logic [IW-1:0] idx_raw;
  logic [IW-1:0] idx;
  logic          blank;
  logic [7:0]    rd_char;
  logic [13:0]   font_seg;
  logic [2:0]    slot;

  assign shadow      = ~active_q;
  assign act_len     = len_q[active_q];
  assign span        = IW'(act_len) + IW'(GAP);
  assign scroll_en   = act_len > LW'(8);
  assign tick        = tick_q == TW'(Ticks - 1);
  // Start has priority over End and over a same-cycle data beat.
  assign commit      = (load_state_q == StLoad) && End_i && !Start_i;
  assign accept      = Valid_i && Ready_o && !Start_i;
  assign scroll_req  = tick && scroll_en && !commit;
  assign refresh_req = commit || scroll_req;

  // Load FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      load_state_q <= StIdle;
    end else begin
      load_state_q <= load_state_d;
    end
  end

  // Load FSM next state.
  always_comb begin
    load_state_d = load_state_q;
    if (Start_i) begin
      load_state_d = StLoad;
    end else if (load_state_q == StLoad && End_i) begin
      load_state_d = StIdle;
    end
  end

  // Load FSM outputs: ready only while loading with room left in the shadow bank.
  always_comb begin
    Ready_o = (load_state_q == StLoad) && (len_q[shadow] < LW'(DEPTH));
  end

  // Shadow bank writes, length bookkeeping and bank swap.
  always_comb begin
    mem_d    = mem_q;
    len_d    = len_q;
    active_d = active_q;
    if (Start_i) begin
      len_d[shadow] = '0;
    end else begin
      if (accept) begin
        mem_d[shadow][len_q[shadow][AW-1:0]] = Char_i;
        len_d[shadow] = len_q[shadow] + LW'(1);
      end
      if (commit) begin
        active_d = ~active_q;
      end
    end
  end

  // Scroll tick counter and offset; a commit restarts both.
  always_comb begin
    tick_d   = tick ? '0 : tick_q + TW'(1);
    offset_d = offset_q;
    if (commit) begin
      tick_d   = '0;
      offset_d = '0;
    end else if (scroll_req) begin
      if (offset_q + IW'(1) == span) begin
        offset_d = '0;
      end else begin
        offset_d = offset_q + IW'(1);
      end
    end
  end

  // Refresh FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ref_state_q <= StWait;
    end else begin
      ref_state_q <= ref_state_d;
    end
  end

  // Refresh FSM next state: eight fetch cycles then one commit.
  always_comb begin
    ref_state_d = ref_state_q;
    unique case (ref_state_q)
      StWait: begin
        if (refresh_req || pending_q) begin
          ref_state_d = StFetch;
        end
      end
      StFetch: begin
        if (digit_q == 3'd7) begin
          ref_state_d = StCommit;
        end
      end
      StCommit: ref_state_d = StWait;
      default:  ref_state_d = StWait;
    endcase
  end

  // Refresh FSM outputs.
  always_comb begin
    Updated_o = (ref_state_q == StCommit);
  end

  // Requests arriving while busy collapse into one pending flag.
  always_comb begin
    pending_d = pending_q;
    if (ref_state_q == StWait) begin
      pending_d = 1'b0;
    end else if (refresh_req) begin
      pending_d = 1'b1;
    end
  end

  // Index of the character shown on the digit being fetched.
  always_comb begin
    idx_raw = offset_q + IW'(digit_q);
    if (!scroll_en) begin
      idx = IW'(digit_q);
    end else if (idx_raw >= span) begin
      idx = idx_raw - span;
    end else begin
      idx = idx_raw;
    end
    blank   = idx >= IW'(act_len);
    rd_char = mem_q[active_q][idx[AW-1:0]];
  end

  vim828_font14 u_font (
    .code_i (rd_char[6:0]),
    .seg_o  (font_seg)
  );

  // Staging fill during FETCH (digit 0 lands in slot 7) and atomic copy-out in COMMIT.
  always_comb begin
    slot        = ~digit_q;
    stage_seg_d = stage_seg_q;
    stage_dp_d  = stage_dp_q;
    digit_d     = '0;
    out_seg_d   = out_seg_q;
    out_dp_d    = out_dp_q;
    if (ref_state_q == StFetch) begin
      stage_seg_d[slot] = blank ? BLANK : font_seg;
      stage_dp_d[slot]  = blank ? 1'b0 : rd_char[7];
      digit_d           = digit_q + 3'd1;
    end
    if (ref_state_q == StCommit) begin
      out_seg_d = stage_seg_q;
      out_dp_d  = stage_dp_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      len_q       <= '{default: '0};
      active_q    <= 1'b0;
      offset_q    <= '0;
      tick_q      <= '0;
      pending_q   <= 1'b0;
      digit_q     <= '0;
      stage_seg_q <= '{default: '0};
      stage_dp_q  <= '0;
      out_seg_q   <= '{default: '0};
      out_dp_q    <= '0;
    end else begin
      len_q       <= len_d;
      active_q    <= active_d;
      offset_q    <= offset_d;
      tick_q      <= tick_d;
      pending_q   <= pending_d;
      digit_q     <= digit_d;
      stage_seg_q <= stage_seg_d;
      stage_dp_q  <= stage_dp_d;
      out_seg_q   <= out_seg_d;
      out_dp_q    <= out_dp_d;
    end
  end

  // Message storage; contents are only meaningful below each bank's length.
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

  assign Segments7_o     = out_seg_q[7];
  assign Segments6_o     = out_seg_q[6];
  assign Segments5_o     = out_seg_q[5];
  assign Segments4_o     = out_seg_q[4];
  assign Segments3_o     = out_seg_q[3];
  assign Segments2_o     = out_seg_q[2];
  assign Segments1_o     = out_seg_q[1];
  assign Segments0_o     = out_seg_q[0];
  assign DecimalPoints_o = out_dp_q;

endmodule

// File: doc/vim828_text_controller.md
# vim828_text_controller

Text front-end for the VIM828 8-digit, 14-segment LCD driver. It accepts a character string over a valid/ready byte stream into a double-buffered message memory and converts the string to segment patterns through a font ROM. It drives the driver's `Segments7_i..Segments0_i` and `DecimalPoints_i` inputs. Strings of up to 8 characters are shown static; longer strings scroll left at a fixed rate.

## Interface

**Parameters**
- `CLOCK_HZ`, default 1_000_000: system clock frequency.
- `SCROLL_MS`, default 300: scroll step period in milliseconds.
- `DEPTH`, default 32: message capacity in characters (power of two, ≥ 8).
- `GAP`, default 3: blank digits inserted between the end and the restart of a scrolling message.

**Ports**
- `Clock` in 1: system clock. One clock domain only.
- `Reset` in 1: synchronous, active-high reset.
- `Start_i` in 1: one-cycle pulse that begins loading a new message.
- `End_i` in 1: one-cycle pulse that commits the loaded message.
- `Char_i` in 8: bits [6:0] are 7-bit ASCII; bit 7 lights the decimal point of that digit.
- `Valid_i` in 1: `Char_i` is valid.
- `Ready_o` out 1: controller accepts a character this cycle.
- `Segments7_o..Segments0_o` out 14 each: bit order NMLK_JIHGF_EDCBA. `Segments7_o` is the leftmost digit.
- `DecimalPoints_o` out 8: bit 7 is the leftmost digit.
- `Updated_o` out 1: one-cycle pulse when the outputs take a new frame.

## Operation

**Memory**
- Two banks of `DEPTH` × 8 bits: a shadow bank (being loaded) and an active bank (being displayed).
- Each bank has its own length register, sized `$clog2(DEPTH)+1` bits.

**Load FSM**
- States: `IDLE`, `LOAD`.
- `Start_i` from either state → `LOAD`. Shadow length is cleared, so any partial load is discarded.
- `Ready_o` = (state == `LOAD`) && (shadow length < `DEPTH`).
- When `Valid_i && Ready_o`: write `Char_i` to shadow[length], then length += 1.
- `End_i` in `LOAD`:
  - Swap banks (shadow becomes active).
  - Clear the scroll offset and the tick counter.
  - Request a refresh.
  - Go to `IDLE`.
- `End_i` in `IDLE` is ignored.
- `Start_i` and `End_i` in the same cycle: `Start_i` wins.
- A `Valid_i` beat in the same cycle as `Start_i` is not accepted (`Ready_o` is 0 that cycle unless already in `LOAD`, and the write is dropped by the clear).
- The active bank keeps displaying during `LOAD`.

**Scroll**
- Define L = active length. Scrolling is enabled iff L > 8.
- Tick counter period = `CLOCK_HZ/1000*SCROLL_MS` cycles.
- On each tick with scrolling enabled:
  - offset = (offset + 1) mod (L + `GAP`).
  - Request a refresh.
- With L ≤ 8, the offset stays 0 and no ticks request refreshes.

**Refresh FSM**
- States: `WAIT`, `FETCH`, `COMMIT`.
- A refresh request in `WAIT` → `FETCH`. `FETCH` runs 8 cycles, digit k = 0..7 (k = 0 is leftmost).
- Digit k reads index i = offset + k, minus (L + `GAP`) if i ≥ L + `GAP` (subtract at most once).
- If L ≤ 8, i = k with no wrap.
- If i ≥ L, the digit is blank: segments 0, decimal point 0.
- Otherwise: segments = font(char[6:0]) and decimal point = char[7], written to a staging register.
- `COMMIT`:
  - Staging copies to all outputs in one cycle.
  - `Updated_o` = 1.
  - Return to `WAIT`.
- A request that arrives during `FETCH`/`COMMIT` is held pending and serviced immediately after. Pending requests collapse to one.

**Font**
- 0x20–0x5F: defined glyphs. 0x20 = blank; '1' = 14'h0006 (B, C).
- 0x61–0x7A: mapped to uppercase.
- All other codes: blank.

**Reset**
- All segment outputs and `DecimalPoints_o` = 0; `Ready_o` = 0; `Updated_o` = 0.
- Both lengths = 0, offset = 0, tick counter = 0.
- Load FSM = `IDLE`, refresh FSM = `WAIT`, no pending request.
- Reset mid-load or mid-refresh aborts with no partial output update.

## Timing

- Character accept: same cycle as `Valid_i && Ready_o`.
- `End_i` at cycle n:
  - Bank swap at n+1.
  - `FETCH` cycles n+1..n+8.
  - `COMMIT`/`Updated_o` at n+9; outputs hold the new values from n+10.
- Scroll tick at cycle t: `Updated_o` at t+9.
- Outputs change only in `COMMIT`, so all 8 digits are glitch-free and atomic.
- `Ready_o` is registered from state and length; it is never combinational from `Valid_i`.

## Structure

- Package `vim828_pkg`:
  - Segment bit-position constants A..N.
  - Load and refresh state encodings.
  - `BLANK` constant 14'h0000.
- Sub-module `vim828_font14`: combinational 7-bit ASCII → 14-bit ROM, instantiated once and shared by the `FETCH` sequence.

## Test plan

- **Static string:** Reset; Start; send "1" with bit 7 set; End at cycle n. Required: `Updated_o` at n+9, `Segments7_o` = 14'h0006, `DecimalPoints_o` = 8'b1000_0000, other digits 0.
- **Backpressure:** `DEPTH` = 32; send 33 beats with `Valid_i` held high. Required: `Ready_o` falls after the 32nd accept, and the 33rd beat stays pending until the next Start.
- **Scroll wrap:** `CLOCK_HZ` = 1e6, `SCROLL_MS` = 1, 10-char message, `GAP` = 3. Required: `Updated_o` every 1000 cycles, and the display returns to offset 0 after 13 ticks.
- **Load while displaying:** Start mid-scroll. Required: scrolling continues unchanged until End, then offset 0 shows the new text.
- **Start+End collision:** same-cycle pulse. Required: the FSM stays in `LOAD` with length 0, and the active bank is unchanged.
- **Reset mid-FETCH:** assert `Reset` at `FETCH` cycle 4. Required: outputs 0, no `Updated_o`, `Ready_o` 0.
